// File: rtl/gb_apu_i2s_tx.sv
// gb_apu_i2s_tx
// Philips I2S transmitter for the gb_apu mixer outputs. BCLK, LRCLK and
// serial data are all derived from the APU system clock by integer division.
// One 32-bit frame ({left, right}, MSB first, two's complement) goes out
// every 64*BCLK_DIV clk cycles.
//
// Ports
//   clk              in   APU system clock, all state on its rising edge
//   reset            in   asynchronous, active-high reset
//   left[15:0]       in   left sample (signed), captured at frame load
//   right[15:0]      in   right sample (signed), captured at frame load
//   mute             in   when high at frame load the frame is all zeros
//   bclk_o           out  I2S bit clock (registered, 50% duty)
//   lrclk_o          out  I2S word select, 0 = left, 1 = right (registered)
//   sdata_o          out  I2S serial data (shift register MSB)
//   sample_strobe_o  out  one-clk pulse in the cycle after a frame load
module gb_apu_i2s_tx #(
  parameter int BCLK_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] left,
  input  logic [15:0] right,
  input  logic        mute,
  output logic        bclk_o,
  output logic        lrclk_o,
  output logic        sdata_o,
  output logic        sample_strobe_o
);

  // At least one bit wide even when BCLK_DIV = 1 (divider then stays at 0).
  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DIV_W-1:0] r_div;
  logic             r_bclk;
  logic [4:0]       r_bit_cnt;
  logic             r_lrclk;
  logic [31:0]      r_shift;
  logic             r_strobe;

  logic             w_div_tc;
  logic             w_shift;
  logic [4:0]       w_bit_nxt;
  logic             w_load;
  logic             w_lrclk_nxt;

  assign w_div_tc    = (r_div == DIV_W'(BCLK_DIV - 1));
  // A terminal count while BCLK is high is the toggle to 0: the falling edge.
  assign w_shift     = w_div_tc && r_bclk;
  assign w_bit_nxt   = r_bit_cnt + 5'd1;
  assign w_load      = (r_bit_cnt == 5'd31);
  // Word select changes one bit ahead of each word's MSB.
  assign w_lrclk_nxt = (w_bit_nxt >= 5'd15) && (w_bit_nxt <= 5'd30);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div     <= '0;
      r_bclk    <= 1'b0;
      r_bit_cnt <= 5'd31;
      r_lrclk   <= 1'b0;
      r_shift   <= '0;
      r_strobe  <= 1'b0;
    end else begin
      r_strobe <= 1'b0;

      if (w_div_tc) begin
        r_div  <= '0;
        r_bclk <= ~r_bclk;
      end else begin
        r_div  <= r_div + DIV_W'(1);
      end

      if (w_shift) begin
        r_bit_cnt <= w_bit_nxt;
        r_lrclk   <= w_lrclk_nxt;
        if (w_load) begin
          r_shift  <= mute ? 32'd0 : {left, right};
          r_strobe <= 1'b1;
        end else begin
          r_shift  <= {r_shift[30:0], 1'b0};
        end
      end
    end
  end

  assign bclk_o          = r_bclk;
  assign lrclk_o         = r_lrclk;
  assign sdata_o         = r_shift[31];
  assign sample_strobe_o = r_strobe;

endmodule

// File: tb/tb_gb_apu_i2s_tx.sv
module tb_gb_apu_i2s_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: BCLK_DIV = 2
  logic        rst_a = 1'b1;
  logic [15:0] left_a = '0, right_a = '0;
  logic        mute_a = 1'b0;
  logic        bclk_a, lrclk_a, sdata_a, strobe_a;

  // Instance B: BCLK_DIV = 1
  logic        rst_b = 1'b1;
  logic [15:0] left_b = 16'h8001, right_b = 16'hFFFF;
  logic        mute_b = 1'b0;
  logic        bclk_b, lrclk_b, sdata_b, strobe_b;

  gb_apu_i2s_tx #(.BCLK_DIV(2)) u_a (
    .clk(clk), .reset(rst_a), .left(left_a), .right(right_a), .mute(mute_a),
    .bclk_o(bclk_a), .lrclk_o(lrclk_a), .sdata_o(sdata_a),
    .sample_strobe_o(strobe_a)
  );

  gb_apu_i2s_tx #(.BCLK_DIV(1)) u_b (
    .clk(clk), .reset(rst_b), .left(left_b), .right(right_b), .mute(mute_b),
    .bclk_o(bclk_b), .lrclk_o(lrclk_b), .sdata_o(sdata_b),
    .sample_strobe_o(strobe_b)
  );

  // Observation mux: sel = 0 watches instance A, 1 watches instance B.
  logic sel = 1'b0;
  wire  w_bclk   = sel ? bclk_b   : bclk_a;
  wire  w_lrclk  = sel ? lrclk_b  : lrclk_a;
  wire  w_sdata  = sel ? sdata_b  : sdata_a;
  wire  w_strobe = sel ? strobe_b : strobe_a;

  int total = 0;
  int bad   = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Waits (bounded) for the next strobe; cyc = falling clk edges waited.
  task automatic wait_strobe(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      cyc++;
      if (w_strobe) ok = 1'b1;
    end
  endtask

  // Captures one frame on 32 BCLK rises following the next strobe.
  // When chg_bit > 0, left_a is changed after that many rises.
  task automatic capture(input int chg_bit, input logic [15:0] chg_val,
                         output logic [31:0] data, output logic [31:0] lr,
                         output bit ok);
    int  cyc;
    int  n;
    logic prev;
    data = '0;
    lr   = '0;
    wait_strobe(cyc, ok);
    if (!ok) return;
    prev = w_bclk;
    n = 0;
    for (int i = 0; i < 300 && n < 32; i++) begin
      @(negedge clk);
      if (w_bclk && !prev) begin
        data  = {data[30:0], w_sdata};
        lr[n] = w_lrclk;
        n++;
        if (n == chg_bit) left_a = chg_val;
      end
      prev = w_bclk;
    end
    ok = (n == 32);
  endtask

  // Reference: bit k of the frame is left on words 0..15, right on 16..31;
  // word select is high for bit slots 15 through 30.
  task automatic check_frame(input string name, input logic [15:0] l,
                             input logic [15:0] r, input logic m);
    logic [31:0] data, lr, exp_data, exp_lr;
    bit ok;
    capture(0, 16'h0, data, lr, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_capture: frame not captured within cycle budget", name);
      return;
    end
    exp_data = m ? 32'd0 : {l, r};
    for (int k = 0; k < 32; k++) exp_lr[k] = (k >= 15 && k <= 30);
    total++;
    if (data !== exp_data) begin
      bad++;
      $display("FAIL %s_data: got=%h exp=%h", name, data, exp_data);
    end
    if (lr !== exp_lr) begin
      bad++;
      $display("FAIL %s_lrclk: got=%h exp=%h", name, lr, exp_lr);
    end
  endtask

  task automatic test_reset();
    logic exp_bclk, exp_str;
    left_a = 16'hA5C3;
    right_a = 16'h0F0F;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bclk_a, lrclk_a, sdata_a, strobe_a} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_outputs: got=%b exp=0000",
               {bclk_a, lrclk_a, sdata_a, strobe_a});
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      exp_bclk = (e == 2 || e == 3);
      exp_str  = (e == 4);
      total++;
      if (bclk_a !== exp_bclk) begin
        bad++;
        $display("FAIL reset_bclk_edge%0d: got=%b exp=%b", e, bclk_a, exp_bclk);
      end
      total++;
      if (strobe_a !== exp_str) begin
        bad++;
        $display("FAIL reset_strobe_edge%0d: got=%b exp=%b", e, strobe_a, exp_str);
      end
    end
    total++;
    if (sdata_a !== left_a[15]) begin
      bad++;
      $display("FAIL reset_first_bit: got=%b exp=%b", sdata_a, left_a[15]);
    end
  endtask

  task automatic test_basic();
    int c;
    bit ok;
    sel = 1'b0;
    check_frame("basic", 16'hA5C3, 16'h0F0F, 1'b0);
    wait_strobe(c, ok);
    wait_strobe(c, ok);
    total++;
    if (!ok || c != 128) begin
      bad++;
      $display("FAIL basic_strobe_period: got=%0d exp=128", c);
    end
  endtask

  task automatic test_midframe();
    logic [31:0] data, lr;
    bit ok;
    sel = 1'b0;
    left_a = 16'hA5C3;
    right_a = 16'h0F0F;
    capture(6, 16'h1234, data, lr, ok);
    total++;
    if (!ok || data !== 32'hA5C30F0F) begin
      bad++;
      $display("FAIL midframe_current: got=%h exp=%h", data, 32'hA5C30F0F);
    end
    check_frame("midframe_next", 16'h1234, 16'h0F0F, 1'b0);
  endtask

  task automatic test_mute();
    sel = 1'b0;
    left_a = 16'h7FFF;
    right_a = 16'h8000;
    mute_a = 1'b1;
    check_frame("mute_on", left_a, right_a, 1'b1);
    mute_a = 1'b0;
    check_frame("mute_off", 16'h7FFF, 16'h8000, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] l, r;
    logic m;
    sel = 1'b0;
    for (int t = 0; t < 6; t++) begin
      l = 16'($urandom);
      r = 16'($urandom);
      m = ($urandom_range(0, 3) == 0);
      left_a = l;
      right_a = r;
      mute_a = m;
      check_frame($sformatf("random%0d", t), l, r, m);
    end
    mute_a = 1'b0;
  endtask

  task automatic test_reset_midframe();
    int c, n;
    bit ok;
    logic prev;
    sel = 1'b0;
    left_a = 16'hFFFF;
    right_a = 16'hFFFF;
    wait_strobe(c, ok);
    wait_strobe(c, ok);
    prev = bclk_a;
    n = 0;
    for (int i = 0; i < 200 && n < 21; i++) begin
      @(negedge clk);
      if (bclk_a && !prev) n++;
      prev = bclk_a;
    end
    #2 rst_a = 1'b1;
    #1;
    total++;
    if ({bclk_a, lrclk_a, sdata_a, strobe_a} !== 4'b0000) begin
      bad++;
      $display("FAIL async_reset_outputs: got=%b exp=0000",
               {bclk_a, lrclk_a, sdata_a, strobe_a});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    wait_strobe(c, ok);
    total++;
    if (!ok || c != 4) begin
      bad++;
      $display("FAIL async_reset_first_load: got=%0d exp=4", c);
    end
  endtask

  task automatic test_bclk_div1();
    int c, c1, c2;
    bit ok;
    logic prev;
    sel = 1'b1;
    check_frame("div1", 16'h8001, 16'hFFFF, 1'b0);
    wait_strobe(c, ok);
    wait_strobe(c, ok);
    total++;
    if (!ok || c != 64) begin
      bad++;
      $display("FAIL div1_strobe_period: got=%0d exp=64", c);
    end
    c1 = -1;
    c2 = -1;
    prev = bclk_b;
    for (int i = 0; i < 20 && c2 < 0; i++) begin
      @(negedge clk);
      if (bclk_b && !prev) begin
        if (c1 < 0) c1 = i;
        else c2 = i;
      end
      prev = bclk_b;
    end
    total++;
    if (c1 < 0 || c2 < 0 || (c2 - c1) != 2) begin
      bad++;
      $display("FAIL div1_bclk_period: got=%0d exp=2", c2 - c1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_midframe();
    test_mute();
    test_random();
    test_reset_midframe();
    test_bclk_div1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
